forwarding_hazard_unit: RTL and testbench
=========================================

Name: forwarding_hazard_unit

Overview:
- Parametrised successor to the single-issue forwarding logic.
- Tracks in-flight register writers in a shift register of NSTAGES pipeline slots (slot 0 = EX, slot 1 = MEM, …, slot NSTAGES-1 = WB).
- Per-stage result-ready latency generalises load-use to any producer latency.
- Generates per-operand forward selects for the EX instruction, a decode stall, and a saturating stall performance counter.

Parameters:
- NREAD, 2, source operands per instruction.
- NSTAGES, 3, tracked slots, EX through WB; legal range 2 to 7.
- REGW, 5, register index width.
- SELW, $clog2(NSTAGES), width of one forward select.
- CNTW, 16, stall counter width.

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- RST  in  1  reset; asynchronous, active-high.
- adv  in  1  pipeline advance enable, e.g. ihit with no memory wait.
- flush  in  1  squash the decode instruction on this advance.
- id_vld  in  1  decode holds a valid instruction.
- id_rs  in  NREAD*REGW  decode source registers; operand i occupies bits [i*REGW +: REGW].
- id_wsel  in  REGW  decode destination register.
- id_wen  in  1  decode instruction writes a register.
- id_rdy  in  SELW  index of the stage whose output first holds the result: 0 = ALU, 1 = load.
- stall  out  1  hold decode and inject a bubble into EX.
- fsel  out  NREAD*SELW  per EX operand: 0 = register file, s = output of slot s, s ≥ 1.
- stall_cnt  out  CNTW  count of stalled advances.

Behaviour:
- **Slot state.** Each slot holds vld, wsel, wen and rdy. Slot 0 also holds the NREAD source fields.
- **Reset.** RST high clears every slot vld (other slot fields to 0) and stall_cnt to 0. Consequently stall=0 and fsel=0 during and after reset. Reset mid-operation discards all in-flight entries immediately.
- **Live writer.** Slot s is a live writer for register r when vld && wen && wsel==r && r!=0. Register 0 never forwards and never stalls.
- **Hazard (combinational).**
  - For each decode operand r with r!=0, take the youngest live writer, i.e. the lowest s in 0..NSTAGES-2.
  - A hazard exists if that writer's rdy > s: its result will not exist at the output of slot s+1 when the consumer enters EX.
  - Writers in slot NSTAGES-1 never cause a hazard; the register file writes first half and reads second half.
  - stall = id_vld && !flush && (hazard on any operand).
- **fsel (combinational from slot 0 sources).**
  - For each EX operand r with r!=0, fsel = the lowest s ≥ 1 whose slot is a live writer for r; otherwise 0.
  - When the EX slot is not valid, all fsel fields are 0.
  - The youngest writer wins over older writers to the same register.
- **Advance (on clock edge when adv=1).**
  - slot[s] ← slot[s-1] for s = 1..NSTAGES-1; the contents of the last slot are dropped.
  - slot 0 ← bubble (vld=0) if flush || stall || !id_vld; otherwise slot 0 ← the decode fields.
  - flush has priority over stall.
- **Hold (adv=0).** All slots hold and stall_cnt holds. stall and fsel remain valid combinationally; decode may change inputs freely.
- **Stall counter.** stall_cnt increments when adv && stall. It saturates at 2^CNTW-1 and does not wrap.
- **Latency.** stall and fsel are zero-cycle combinational. Slot state updates one cycle after adv.
- **Multi-cycle stalls.** A producer with rdy=k stalls an immediately dependent consumer for k cycles of adv. Each stalled advance moves the producer one slot deeper.

Test Plan (NSTAGES=3 unless stated):
1. **ALU to ALU.** Advance add $3←…; next decode add $4←$3,$1 (operand 0 = $3) -> stall=0; after advance, fsel operand 0 = 1 (MEM) and operand 1 = 0.
2. **Load-use.** lw $5 (id_rdy=1); next decode uses $5 -> stall=1 for exactly one adv and stall_cnt=1; then stall=0; after the following advance fsel=2 (WB).
3. **$zero and priority.** Producers writing $0 -> never stall, fsel=0. Two writers of $7 in slots 1 and 2 -> fsel=1.
4. **Hold and flush.** adv=0 for 5 cycles during a stall -> slots, stall and stall_cnt unchanged. flush=1 together with a hazard -> bubble enters slot 0 and stall=0.
5. **Reset mid-stall.** Assert RST asynchronously mid-cycle -> stall, fsel and stall_cnt read 0 immediately with no clock edge.
6. **Saturation and depth.** CNTW=4 with 20 stalled advances -> stall_cnt=15. NSTAGES=4, rdy=2 producer followed by an immediate dependent -> exactly 2 stalls, then fsel=3.

Source files
------------

// File: rtl/forwarding_hazard_unit.sv
// rtl/forwarding_hazard_unit.sv - parametrised in-flight writer tracking, forward selects and decode stall
module forwarding_hazard_unit #(
  parameter int NREAD   = 2,
  parameter int NSTAGES = 3,
  parameter int REGW    = 5,
  parameter int SELW    = $clog2(NSTAGES),
  parameter int CNTW    = 16
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  adv,
  input  logic                  flush,
  input  logic                  id_vld,
  input  logic [NREAD*REGW-1:0] id_rs,
  input  logic [REGW-1:0]       id_wsel,
  input  logic                  id_wen,
  input  logic [SELW-1:0]       id_rdy,
  output logic                  stall,
  output logic [NREAD*SELW-1:0] fsel,
  output logic [CNTW-1:0]       stall_cnt
);

  // slot 0 = EX, slot NSTAGES-1 = WB
  logic [NSTAGES-1:0] slot_vld;
  logic [NSTAGES-1:0] slot_wen;
  logic [REGW-1:0]    slot_wsel [NSTAGES];
  logic [SELW-1:0]    slot_rdy  [NSTAGES];
  logic [NREAD*REGW-1:0] ex_rs;

  logic hazard;

  // Shift writers one slot deeper on each advance; slot 0 takes decode or a bubble
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      slot_vld <= '0;
      slot_wen <= '0;
      ex_rs    <= '0;
      for (int s = 0; s < NSTAGES; s++) begin
        slot_wsel[s] <= '0;
        slot_rdy[s]  <= '0;
      end
    end else if (adv) begin
      for (int s = 1; s < NSTAGES; s++) begin
        slot_vld[s]  <= slot_vld[s-1];
        slot_wen[s]  <= slot_wen[s-1];
        slot_wsel[s] <= slot_wsel[s-1];
        slot_rdy[s]  <= slot_rdy[s-1];
      end
      if (flush || stall || !id_vld) begin
        slot_vld[0]  <= 1'b0;
        slot_wen[0]  <= 1'b0;
        slot_wsel[0] <= '0;
        slot_rdy[0]  <= '0;
        ex_rs        <= '0;
      end else begin
        slot_vld[0]  <= 1'b1;
        slot_wen[0]  <= id_wen;
        slot_wsel[0] <= id_wsel;
        slot_rdy[0]  <= id_rdy;
        ex_rs        <= id_rs;
      end
    end
  end

  // Youngest live writer of each decode operand decides whether its result is late
  always_comb begin
    logic [REGW-1:0] rs;
    logic            found;
    hazard = 1'b0;
    rs     = '0;
    found  = 1'b0;
    for (int i = 0; i < NREAD; i++) begin
      rs    = id_rs[i*REGW +: REGW];
      found = 1'b0;
      // the WB slot is excluded: the register file writes before it is read
      for (int s = 0; s < NSTAGES-1; s++) begin
        if (!found && rs != '0 && slot_vld[s] && slot_wen[s] && slot_wsel[s] == rs) begin
          found = 1'b1;
          if (slot_rdy[s] > SELW'(s)) hazard = 1'b1;
        end
      end
    end
    stall = id_vld && !flush && hazard;
  end

  // Forward select per EX operand: nearest older live writer, else register file
  always_comb begin
    logic [REGW-1:0] rs;
    logic            found;
    fsel  = '0;
    rs    = '0;
    found = 1'b0;
    for (int i = 0; i < NREAD; i++) begin
      rs    = ex_rs[i*REGW +: REGW];
      found = 1'b0;
      for (int s = 1; s < NSTAGES; s++) begin
        if (!found && slot_vld[0] && rs != '0 && slot_vld[s] && slot_wen[s] && slot_wsel[s] == rs) begin
          found = 1'b1;
          fsel[i*SELW +: SELW] = SELW'(s);
        end
      end
    end
  end

  // Saturating count of advances that inserted a stall bubble
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      stall_cnt <= '0;
    end else if (adv && stall && stall_cnt != '1) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_forwarding_hazard_unit.sv
// tb/tb_forwarding_hazard_unit.sv - directed vector bench for forwarding_hazard_unit
module tb_forwarding_hazard_unit;

  logic        CLK;
  logic        RST;
  logic        adv;
  logic        flush;
  logic        id_vld;
  logic [9:0]  id_rs;
  logic [4:0]  id_wsel;
  logic        id_wen;
  logic [1:0]  id_rdy;

  logic        stall_m, stall_s, stall_d;
  logic [3:0]  fsel_m, fsel_s, fsel_d;
  logic [15:0] cnt_m, cnt_d;
  logic [3:0]  cnt_s;

  int vectors;
  int miscompares;

  forwarding_hazard_unit u_main (
    .CLK(CLK), .RST(RST), .adv(adv), .flush(flush), .id_vld(id_vld),
    .id_rs(id_rs), .id_wsel(id_wsel), .id_wen(id_wen), .id_rdy(id_rdy),
    .stall(stall_m), .fsel(fsel_m), .stall_cnt(cnt_m)
  );

  forwarding_hazard_unit #(.CNTW(4)) u_sat (
    .CLK(CLK), .RST(RST), .adv(adv), .flush(flush), .id_vld(id_vld),
    .id_rs(id_rs), .id_wsel(id_wsel), .id_wen(id_wen), .id_rdy(id_rdy),
    .stall(stall_s), .fsel(fsel_s), .stall_cnt(cnt_s)
  );

  forwarding_hazard_unit #(.NSTAGES(4)) u_deep (
    .CLK(CLK), .RST(RST), .adv(adv), .flush(flush), .id_vld(id_vld),
    .id_rs(id_rs), .id_wsel(id_wsel), .id_wen(id_wen), .id_rdy(id_rdy),
    .stall(stall_d), .fsel(fsel_d), .stall_cnt(cnt_d)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic dec(input logic v, input logic [4:0] rs0, input logic [4:0] rs1,
                     input logic [4:0] wsel, input logic wen, input logic [1:0] rdy);
    id_vld  = v;
    id_rs   = {rs1, rs0};
    id_wsel = wsel;
    id_wen  = wen;
    id_rdy  = rdy;
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    RST = 1'b1; adv = 1'b0; flush = 1'b0;
    dec(0, 0, 0, 0, 0, 0);
    repeat (2) cyc();
    chk("rst_stall", stall_m, 0);
    chk("rst_fsel", fsel_m, 0);
    chk("rst_cnt", cnt_m, 0);
    RST = 1'b0;
    adv = 1'b1;

    // ALU to ALU
    dec(1, 1, 2, 3, 1, 0); #1;
    chk("alu_first_nostall", stall_m, 0);
    cyc();
    dec(1, 3, 1, 4, 1, 0); #1;
    chk("alu_dep_nostall", stall_m, 0);
    cyc();
    // load-use
    dec(1, 1, 0, 5, 1, 1); #1;
    chk("alu_fsel_mem", fsel_m, 4'h1);
    chk("lw_issue_nostall", stall_m, 0);
    cyc();
    dec(1, 5, 0, 6, 1, 0); #1;
    chk("lu_stall", stall_m, 1);
    chk("lu_cnt0", cnt_m, 0);
    cyc();
    chk("lu_stall_clear", stall_m, 0);
    chk("lu_cnt1", cnt_m, 1);
    chk("lu_bubble_fsel", fsel_m, 0);
    cyc();
    dec(1, 0, 0, 0, 1, 1); #1;
    chk("lu_fsel_wb", fsel_m, 4'h2);
    chk("zero_dec_nostall", stall_m, 0);
    cyc();
    // $zero writers
    chk("zero_nostall2", stall_m, 0);
    chk("zero_fsel", fsel_m, 0);
    cyc();
    chk("zero_fsel_mem", fsel_m, 0);
    // two writers of $7
    dec(1, 0, 0, 7, 1, 0); cyc();
    dec(1, 0, 0, 7, 1, 0); cyc();
    dec(1, 1, 7, 8, 1, 0); #1;
    chk("prio_nostall", stall_m, 0);
    cyc();
    dec(1, 0, 0, 9, 1, 1); #1;
    chk("prio_fsel_young", fsel_m, 4'h4);
    cyc();
    // hold during a stall
    dec(1, 9, 0, 10, 1, 0); #1;
    chk("hold_stall_pre", stall_m, 1);
    adv = 1'b0;
    repeat (5) cyc();
    chk("hold_stall", stall_m, 1);
    chk("hold_cnt", cnt_m, 1);
    chk("hold_fsel", fsel_m, 0);
    // flush beats stall
    flush = 1'b1;
    adv = 1'b1; #1;
    chk("flush_stall", stall_m, 0);
    cyc();
    flush = 1'b0; #1;
    chk("flush_cnt", cnt_m, 1);
    chk("flush_bubble_fsel", fsel_m, 0);
    chk("flush_after_stall", stall_m, 0);
    cyc();
    // async reset mid-stall
    dec(1, 0, 0, 11, 1, 1); cyc();
    dec(1, 11, 0, 12, 1, 0); #1;
    chk("rst_mid_pre_stall", stall_m, 1);
    #2 RST = 1'b1;
    #1;
    chk("rst_mid_stall", stall_m, 0);
    chk("rst_mid_fsel", fsel_m, 0);
    chk("rst_mid_cnt", cnt_m, 0);
    cyc();
    RST = 1'b0;
    // saturation: 20 stalled advances
    for (int k = 0; k < 20; k++) begin
      dec(1, 0, 0, 12, 1, 1); cyc();
      dec(1, 12, 0, 13, 0, 0); cyc();
    end
    chk("sat_main_cnt", cnt_m, 20);
    chk("sat_cnt4", cnt_s, 15);
    // depth: NSTAGES=4 with rdy=2 producer
    RST = 1'b1;
    cyc();
    RST = 1'b0;
    chk("deep_rst_cnt", cnt_d, 0);
    dec(1, 0, 0, 13, 1, 2); cyc();
    dec(1, 13, 0, 14, 1, 0); #1;
    chk("deep_stall1", stall_d, 1);
    cyc();
    chk("deep_stall2", stall_d, 1);
    cyc();
    chk("deep_go", stall_d, 0);
    chk("deep_cnt", cnt_d, 2);
    cyc();
    chk("deep_fsel", fsel_d, 4'h3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
